memory_cycle: RTL
=================

Name: memory_cycle

Overview:
- Memory (M) stage of the 5-stage RISC-V pipeline.
- Consumes the E/M register outputs of the execute stage and performs the load/store on a ready-handshaked data bus.
- Stalls upstream while the access is pending and drives the M/W pipeline register that feeds writeback.
- Word accesses only; flags misaligned addresses and bus timeouts.

Parameters:
- TIMEOUT_CYCLES, 255: maximum number of cycles dmem_req is held without dmem_ready before the access is aborted (≥1).

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous reset, active-low
RegWriteM  in  1  register-file write enable from E/M register
MemWriteM  in  1  store request
ResultSrcM  in  1  1 = load (writeback selects read data)
RD_M  in  5  destination register
PCPlus4M  in  32  PC+4 of the instruction
WriteDataM  in  32  store data (already forwarded)
ALU_ResultM  in  32  effective address / ALU result
dmem_req  out  1  bus request
dmem_we  out  1  1 = write
dmem_addr  out  32  word address (= ALU_ResultM)
dmem_wdata  out  32  store data
dmem_rdata  in  32  load data, valid when dmem_req & dmem_ready
dmem_ready  in  1  access completes this cycle
StallM  out  1  hold PC, IF/ID, ID/EX and E/M registers this cycle
RegWriteW, ResultSrcW  out  1  M/W register control
RD_W  out  5  M/W destination
PCPlus4W, ALU_ResultW, ReadDataW  out  32  M/W data
MisalignM  out  1  one-cycle error pulse
BusErrM  out  1  one-cycle timeout pulse

Behaviour:
- op = MemWriteM | ResultSrcM. A store has priority when both are set (dmem_we = MemWriteM).
- misaligned = op & (ALU_ResultM[1:0] != 0).
- FSM states: IDLE, WAIT. Wait counter cnt, width $clog2(TIMEOUT_CYCLES+1).
- IDLE, no op: dmem_req=0, StallM=0. M/W loads the inputs.
- IDLE, misaligned: dmem_req=0, StallM=0. M/W loads a bubble (RegWriteW=0). MisalignM=1 next cycle.
- IDLE, op aligned: dmem_req=1 combinationally, same cycle.
  - If dmem_ready: zero-wait completion. StallM=0, M/W loads the inputs, ReadDataW=dmem_rdata.
  - Otherwise: StallM=1, M/W loads a bubble, go to WAIT with cnt=1.
- WAIT, cnt < TIMEOUT_CYCLES: dmem_req=1; addr/we/wdata come from the held E/M inputs.
  - If dmem_ready: StallM=0, M/W loads the inputs plus rdata, go to IDLE.
  - Otherwise: StallM=1, bubble into M/W, cnt++.
- WAIT, cnt == TIMEOUT_CYCLES (abort cycle): dmem_req=0 and dmem_ready is ignored. StallM=0, M/W loads a bubble, go to IDLE. BusErrM=1 next cycle.
- dmem_req is therefore high for exactly TIMEOUT_CYCLES cycles before an abort.
- ReadDataW updates only on a completing load. It holds otherwise.
- MisalignM and BusErrM are registered, one cycle wide, and never both high.
- Reset (rst=0 at posedge):
  - state=IDLE, cnt=0.
  - All W outputs = 0; MisalignM = BusErrM = 0.
  - While rst=0, dmem_req and StallM are forced to 0 combinationally.
  - A reset during WAIT abandons the access silently, with no BusErrM.
- dmem_req, dmem_we, dmem_addr, dmem_wdata and StallM are combinational from the state and the E/M inputs. All other outputs are registered.

Decomposition:
- Shared package memory_cycle_pkg: the state enum (IDLE, WAIT) and WORD_ALIGN_MASK=2'b11.
- One sub-module, mw_pipe_reg: the M/W register with load/bubble select and synchronous active-low reset.
- FSM, counter and error pulses stay in memory_cycle.

Test Plan:
1. Load, zero-wait: ResultSrcM=1, ALU_ResultM=0x100, dmem_ready=1, dmem_rdata=0xDEADBEEF.
   → dmem_req=1 and StallM=0 the same cycle. Next cycle ReadDataW=0xDEADBEEF, RegWriteW=1, ResultSrcW=1.
2. Store, 3 wait states: MemWriteM=1, ALU_ResultM=0x200, WriteDataM=0x12345678, ready asserted on the 4th req cycle.
   → dmem_we=1, StallM=1 for 3 cycles. M/W holds bubbles during the stall, then loads RegWriteW=0.
3. Timeout, TIMEOUT_CYCLES=4, store with dmem_ready never asserted.
   → dmem_req high for 4 cycles. Abort cycle has req=0 and StallM=0. BusErrM pulses 1 cycle. No retry follows.
4. Misaligned load: ALU_ResultM=0x102.
   → dmem_req never asserted, StallM=0, RegWriteW=0 next cycle, MisalignM single-cycle pulse.
5. Reset mid-WAIT: pull rst low on the 2nd wait cycle.
   → dmem_req and StallM drop immediately. After the edge, all W outputs are 0, BusErrM stays 0, and a fresh load completes normally after rst=1.
6. Non-memory ALU op with RegWriteM=1, RD_M=5, ALU_ResultM=7.
   → no req, no stall. Next cycle RD_W=5, ALU_ResultW=7, RegWriteW=1.

Source files
------------

// File: rtl/memory_cycle_pkg.sv
// Shared types and constants for the memory (M) stage of the RISC-V pipeline.
package memory_cycle_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr[1:0] & WORD_ALIGN_MASK) != 2'b00;
    endfunction

endpackage

// File: rtl/mw_pipe_reg.sv
// M/W pipeline register: loads the M-stage result or a bubble each cycle.
// ReadData has its own enable so it only changes on a completing load.
module mw_pipe_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic        rdata_en_i,
    input  logic        reg_write_i,
    input  logic        result_src_i,
    input  logic [4:0]  rd_i,
    input  logic [31:0] pc_plus4_i,
    input  logic [31:0] alu_result_i,
    input  logic [31:0] read_data_i,
    output logic        reg_write_o,
    output logic        result_src_o,
    output logic [4:0]  rd_o,
    output logic [31:0] pc_plus4_o,
    output logic [31:0] alu_result_o,
    output logic [31:0] read_data_o
);

    logic        reg_write_q, reg_write_d;
    logic        result_src_q, result_src_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] pc_plus4_q, pc_plus4_d;
    logic [31:0] alu_result_q, alu_result_d;
    logic [31:0] read_data_q, read_data_d;

    // A bubble clears every field except ReadData, which simply holds.
    always_comb begin
        reg_write_d  = 1'b0;
        result_src_d = 1'b0;
        rd_d         = '0;
        pc_plus4_d   = '0;
        alu_result_d = '0;
        read_data_d  = rdata_en_i ? read_data_i : read_data_q;
        if (load_i) begin
            reg_write_d  = reg_write_i;
            result_src_d = result_src_i;
            rd_d         = rd_i;
            pc_plus4_d   = pc_plus4_i;
            alu_result_d = alu_result_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            reg_write_q  <= 1'b0;
            result_src_q <= 1'b0;
            rd_q         <= '0;
            pc_plus4_q   <= '0;
            alu_result_q <= '0;
            read_data_q  <= '0;
        end else begin
            reg_write_q  <= reg_write_d;
            result_src_q <= result_src_d;
            rd_q         <= rd_d;
            pc_plus4_q   <= pc_plus4_d;
            alu_result_q <= alu_result_d;
            read_data_q  <= read_data_d;
        end
    end

    assign reg_write_o  = reg_write_q;
    assign result_src_o = result_src_q;
    assign rd_o         = rd_q;
    assign pc_plus4_o   = pc_plus4_q;
    assign alu_result_o = alu_result_q;
    assign read_data_o  = read_data_q;

endmodule

// File: rtl/memory_cycle.sv
// Memory stage: word load/store over a ready-handshaked bus with wait-state
// stalling, timeout abort and misalignment detection, feeding the M/W register.
module memory_cycle
    import memory_cycle_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteM,
    input  logic        MemWriteM,
    input  logic        ResultSrcM,
    input  logic [4:0]  RD_M,
    input  logic [31:0] PCPlus4M,
    input  logic [31:0] WriteDataM,
    input  logic [31:0] ALU_ResultM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ready,
    output logic        StallM,
    output logic        RegWriteW,
    output logic        ResultSrcW,
    output logic [4:0]  RD_W,
    output logic [31:0] PCPlus4W,
    output logic [31:0] ALU_ResultW,
    output logic [31:0] ReadDataW,
    output logic        MisalignM,
    output logic        BusErrM
);

    localparam int             CW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(TIMEOUT_CYCLES);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          misalign_q, misalign_d;
    logic          buserr_q, buserr_d;

    logic op, misaligned, abort;
    logic req_raw, mw_load, rdata_en;

    assign op         = MemWriteM | ResultSrcM;
    assign misaligned = op & is_misaligned(ALU_ResultM);
    assign abort      = (state_q == WAIT) && (cnt_q == CNT_MAX);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            misalign_q <= 1'b0;
            buserr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            misalign_q <= misalign_d;
            buserr_q   <= buserr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (op && !misaligned && !dmem_ready) begin
                    state_d = WAIT;
                    cnt_d   = CW'(1);
                end
            end
            WAIT: begin
                if (abort || dmem_ready) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // The abort cycle drops the request, so a late ready is never seen.
    always_comb begin
        req_raw    = 1'b0;
        mw_load    = 1'b0;
        misalign_d = 1'b0;
        buserr_d   = 1'b0;
        case (state_q)
            IDLE: begin
                req_raw    = op & ~misaligned;
                mw_load    = ~op | (~misaligned & dmem_ready);
                misalign_d = misaligned;
            end
            WAIT: begin
                req_raw  = ~abort;
                mw_load  = ~abort & dmem_ready;
                buserr_d = abort;
            end
            default: ;
        endcase
    end

    assign rdata_en   = mw_load & req_raw & ResultSrcM & ~MemWriteM;
    assign dmem_req   = rst & req_raw;
    assign StallM     = rst & req_raw & ~dmem_ready;
    assign dmem_we    = MemWriteM;
    assign dmem_addr  = ALU_ResultM;
    assign dmem_wdata = WriteDataM;
    assign MisalignM  = misalign_q;
    assign BusErrM    = buserr_q;

    mw_pipe_reg u_mw (
        .clk          (clk),
        .rst          (rst),
        .load_i       (mw_load),
        .rdata_en_i   (rdata_en),
        .reg_write_i  (RegWriteM),
        .result_src_i (ResultSrcM),
        .rd_i         (RD_M),
        .pc_plus4_i   (PCPlus4M),
        .alu_result_i (ALU_ResultM),
        .read_data_i  (dmem_rdata),
        .reg_write_o  (RegWriteW),
        .result_src_o (ResultSrcW),
        .rd_o         (RD_W),
        .pc_plus4_o   (PCPlus4W),
        .alu_result_o (ALU_ResultW),
        .read_data_o  (ReadDataW)
    );

endmodule
